// File: rtl/dma_pix_packer_pkg.sv
// Shared definitions for the frame-buffer write DMA pixel packer.
// Provides the constant clog2, the fill-counter width helper and the
// configuration legality check used at elaboration time.
package dma_pkg;

  localparam int PIX_W_DEF  = 24;
  localparam int WORD_W_DEF = 32;
  localparam int LW_W_DEF   = 12;

  // Ceiling log2. Used only on parameters, so it folds to a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of the fill count. One extra bit holds fill+PIX_W before the
  // word-complete subtraction, which can reach 2*WORD_W-1.
  function automatic int fill_width(input int word_w);
    return clog2(word_w) + 1;
  endfunction

  function automatic bit cfg_legal(input int pix_w, input int word_w);
    return (pix_w > 0) && (pix_w % 8 == 0) && (word_w % 8 == 0) && (pix_w <= word_w);
  endfunction

endpackage

// File: rtl/dma_pix_packer_if.sv
// Pixel-in / word-out bundle between the video source, the packer and the
// DMA address generator.
// slave  : packer side (consumes rst/de/pixel, produces word/eol/count/ovf)
// master : source + address-generator side
interface dma_pix_packer_if #(
  parameter int PIX_W  = 24,
  parameter int WORD_W = 32,
  parameter int LW_W   = 12
);
  logic              dma_rst_i;
  logic              dma_de_i;
  logic [PIX_W-1:0]  dma_d_i;
  logic              dma_de_o;
  logic              dma_we_o;
  logic [WORD_W-1:0] dma_d_o;
  logic              dma_eol_o;
  logic [LW_W-1:0]   dma_line_words_o;
  logic              dma_ovf_o;

  modport slave (
    input  dma_rst_i, dma_de_i, dma_d_i,
    output dma_de_o, dma_we_o, dma_d_o, dma_eol_o, dma_line_words_o, dma_ovf_o
  );

  modport master (
    output dma_rst_i, dma_de_i, dma_d_i,
    input  dma_de_o, dma_we_o, dma_d_o, dma_eol_o, dma_line_words_o, dma_ovf_o
  );
endinterface

// File: rtl/dma_pix_packer.sv
// Purpose : packs PIX_W-bit pixels into WORD_W-bit words (first pixel in LSBs),
//           optional zero-padded flush at line end, per-line word count.
// Latency : 1 cycle from the word-completing pixel (or line end) to dma_we_o.
// Backpressure: none; one pixel accepted every dma_de_i cycle.
// Ports   : sys_clk, rst_n (async, active low); bus (slave modport) carries
//           dma_rst_i/dma_de_i/dma_d_i in and de/we/word/eol/count/ovf out.
module dma_pix_packer
  import dma_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  parameter int PAD_LINE = 1,
  parameter int LW_W     = LW_W_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  dma_pix_packer_if.slave bus
);

  localparam int ACC_W  = WORD_W + PIX_W;
  localparam int FILL_W = fill_width(WORD_W);
  localparam logic [FILL_W-1:0] PIX_F  = FILL_W'(PIX_W);
  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);

  generate
    if (!cfg_legal(PIX_W, WORD_W)) begin : g_bad_cfg
      $error("dma_pix_packer: PIX_W/WORD_W must be multiples of 8 with PIX_W <= WORD_W");
    end
  endgenerate

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              de_q, de_q_d;
  logic              de_o_q, de_o_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              eol_q, eol_d;
  logic [LW_W-1:0]   cnt_q, cnt_d;
  logic [LW_W-1:0]   lw_q, lw_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W-1:0]  acc_ins;
  logic [FILL_W-1:0] fill_sum;
  logic [LW_W:0]     cnt_inc;

  always_comb begin
    // Bits of acc at and above fill are always zero, so OR-ing inserts the pixel.
    acc_ins  = acc_q | (ACC_W'(bus.dma_d_i) << fill_q);
    fill_sum = fill_q + PIX_F;
    cnt_inc  = {1'b0, cnt_q} + (LW_W+1)'(1);

    acc_d  = acc_q;
    fill_d = fill_q;
    de_q_d = bus.dma_de_i;
    de_o_d = bus.dma_de_i;
    we_d   = 1'b0;
    word_d = word_q;
    eol_d  = 1'b0;
    cnt_d  = cnt_q;
    lw_d   = lw_q;
    ovf_d  = ovf_q;

    if (bus.dma_rst_i) begin
      // Frame restart: any residue is dropped without a flush.
      acc_d  = '0;
      fill_d = '0;
      de_q_d = 1'b0;
      word_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (bus.dma_de_i) begin
      if (fill_sum >= WORD_F) begin
        we_d   = 1'b1;
        word_d = acc_ins[WORD_W-1:0];
        acc_d  = acc_ins >> WORD_W;
        fill_d = fill_sum - WORD_F;
        cnt_d  = cnt_inc[LW_W-1:0];
        if (cnt_inc[LW_W]) ovf_d = 1'b1;
      end else begin
        acc_d  = acc_ins;
        fill_d = fill_sum;
      end
    end else if (de_q) begin
      // Line end. The count reported includes the pad word when one is sent.
      eol_d = 1'b1;
      cnt_d = '0;
      lw_d  = cnt_q;
      if ((PAD_LINE != 0) && (fill_q != '0)) begin
        we_d   = 1'b1;
        word_d = acc_q[WORD_W-1:0];
        acc_d  = '0;
        fill_d = '0;
        lw_d   = cnt_inc[LW_W-1:0];
        if (cnt_inc[LW_W]) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
      de_q   <= 1'b0;
      de_o_q <= 1'b0;
      we_q   <= 1'b0;
      word_q <= '0;
      eol_q  <= 1'b0;
      cnt_q  <= '0;
      lw_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      de_q   <= de_q_d;
      de_o_q <= de_o_d;
      we_q   <= we_d;
      word_q <= word_d;
      eol_q  <= eol_d;
      cnt_q  <= cnt_d;
      lw_q   <= lw_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.dma_de_o         = de_o_q;
  assign bus.dma_we_o         = we_q;
  assign bus.dma_d_o          = word_q;
  assign bus.dma_eol_o        = eol_q;
  assign bus.dma_line_words_o = lw_q;
  assign bus.dma_ovf_o        = ovf_q;

endmodule
